// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bus bundle. Carries the instruction-memory address/data
// pair, the decode valid/ready handshake, redirect/halt control and status.
// The master side is the fetch unit; the slave side is imem plus decode.
interface fetch_if;
    logic [31:0] o_pc;
    logic [31:0] i_instr;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_halt;
    logic        o_halted;
    logic        o_fault;

    modport master (
        output o_pc,
        input  i_instr,
        output o_valid,
        input  i_ready,
        output o_instr,
        output o_instr_pc,
        input  i_redirect,
        input  i_redirect_pc,
        input  i_halt,
        output o_halted,
        output o_fault
    );

    modport slave (
        input  o_pc,
        output i_instr,
        input  o_valid,
        output i_ready,
        input  o_instr,
        input  o_instr_pc,
        output i_redirect,
        output i_redirect_pc,
        output i_halt,
        input  o_halted,
        input  o_fault
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, presents it to a
// combinational instruction memory and registers the returned word plus its
// PC into an output register handed to decode over valid/ready.
// Handles redirect with flush, decode stall, halt and fetch faults.
// Optional build macro FETCH_PERF_CNT_EN adds fetch/flush event counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 2048
) (
    input  logic        i_clk,
    input  logic        i_reset,
    fetch_if.master     bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_flush_cnt
`endif
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);
    localparam logic [31:0] NOP        = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        fault_q, fault_d;

    logic        in_fetch;
    logic        range_fault;
    logic        load;
    logic        redirect_aligned;

    assign in_fetch         = (state_q == ST_FETCH);
    assign range_fault      = (pc_q >= IMEM_LIMIT) || (pc_q[1:0] != 2'b00);
    assign load             = !valid_q || bus.i_ready;
    assign redirect_aligned = (bus.i_redirect_pc[1:0] == 2'b00);

    // State register and fetch output register, cleared asynchronously.
    always_ff @(posedge i_clk or posedge i_reset) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (i_reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= NOP;
            instr_pc_q <= 32'h0000_0000;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            fault_q    <= fault_d;
        end
    end

    // Next-state logic: redirect beats fault check beats load/halt.
    always_comb begin
        // NOTE: every _d defaults to its _q before any branch, so no path
        // through the case can leave a latch behind.
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        fault_d    = fault_q;

        unique case (state_q)
            ST_BOOT: begin
                // One settling cycle after reset; nothing is fetched.
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (bus.i_redirect) begin
                    valid_d = 1'b0;
                    if (redirect_aligned) begin
                        pc_d = bus.i_redirect_pc;
                    end else begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end
                end else if (range_fault) begin
                    valid_d = 1'b0;
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    if (load) begin
                        instr_d    = bus.i_instr;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + 32'd4;
                    end
                    if (bus.i_halt) begin
                        state_d = ST_HALT;
                    end
                end
            end

            ST_HALT: begin
                // PC frozen; only the held instruction may still drain.
                if (valid_q && bus.i_ready) begin
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign bus.o_pc       = pc_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_instr    = instr_q;
    assign bus.o_instr_pc = instr_pc_q;
    assign bus.o_halted   = (state_q == ST_HALT);
    assign bus.o_fault    = fault_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Event counters: loads that set valid, and every accepted redirect.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (in_fetch && bus.i_redirect) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end else if (in_fetch && !range_fault && load) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    // Counter registers, wrapping modulo 2^32.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fetch_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_fetch_cnt = fetch_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. Directed scenarios for
// reset, stall, redirect, misaligned redirect, halt and the IMEM boundary,
// then randomized traffic compared each cycle against a behavioural model.
module tb_fetch_unit;

    localparam int IMEM = 2048;

    logic clk     = 1'b0;
    logic i_reset = 1'b0;

    fetch_if bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_fetch_cnt;
    logic [31:0] o_flush_cnt;
`endif

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (IMEM)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .bus         (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_fetch_cnt (o_fetch_cnt),
        .o_flush_cnt (o_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a distinct word per address.
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    assign bus.i_instr = instr_of(bus.o_pc);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference state.
    logic [31:0] m_pc, m_instr, m_instr_pc, m_fetch, m_flush;
    bit          m_valid, m_boot, m_halt, m_fault;

    task automatic model_reset();
        m_pc       = 32'h0;
        m_instr    = 32'h0000_0013;
        m_instr_pc = 32'h0;
        m_valid    = 0;
        m_boot     = 1;
        m_halt     = 0;
        m_fault    = 0;
        m_fetch    = 0;
        m_flush    = 0;
    endtask

    // One clock edge of the fetch rules, evaluated from pre-edge inputs.
    task automatic model_edge(input bit rdy, input bit rd, input logic [31:0] rpc, input bit hlt);
        if (m_boot) begin
            m_boot = 0;
        end else if (m_halt) begin
            if (m_valid && rdy) m_valid = 0;
        end else if (rd) begin
            m_valid = 0;
            m_flush = m_flush + 1;
            if (rpc % 4 == 0) m_pc = rpc;
            else begin
                m_fault = 1;
                m_halt  = 1;
            end
        end else if (m_pc >= IMEM || m_pc % 4 != 0) begin
            m_valid = 0;
            m_fault = 1;
            m_halt  = 1;
        end else begin
            if (!m_valid || rdy) begin
                m_instr    = instr_of(m_pc);
                m_instr_pc = m_pc;
                m_valid    = 1;
                m_pc       = m_pc + 4;
                m_fetch    = m_fetch + 1;
            end
            if (hlt) m_halt = 1;
        end
    endtask

    task automatic compare_all(input string where);
        check({where, ".pc"},       bus.o_pc,               m_pc);
        check({where, ".valid"},    32'(bus.o_valid),       32'(m_valid));
        check({where, ".instr"},    bus.o_instr,            m_instr);
        check({where, ".instr_pc"}, bus.o_instr_pc,         m_instr_pc);
        check({where, ".halted"},   32'(bus.o_halted),      32'(m_halt));
        check({where, ".fault"},    32'(bus.o_fault),       32'(m_fault));
`ifdef FETCH_PERF_CNT_EN
        check({where, ".fetch_cnt"}, o_fetch_cnt, m_fetch);
        check({where, ".flush_cnt"}, o_flush_cnt, m_flush);
`endif
    endtask

    // Drive inputs, take one rising edge, advance the model, compare.
    task automatic step(input bit rdy, input bit rd, input logic [31:0] rpc, input bit hlt);
        bus.i_ready       = rdy;
        bus.i_redirect    = rd;
        bus.i_redirect_pc = rpc;
        bus.i_halt        = hlt;
        @(posedge clk);
        model_edge(rdy, rd, rpc, hlt);
        #1;
        compare_all("cyc");
    endtask

    // Asynchronous assert, immediate check, release on the falling edge.
    task automatic do_reset();
        bus.i_ready       = 1'b1;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = 32'h0;
        bus.i_halt        = 1'b0;
        i_reset = 1'b1;
        #1;
        model_reset();
        compare_all("rst");
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    initial begin
        logic [31:0] rpc;
        int          r;
        int          post;
        bit          rdy, rd, hlt;

        #2;
        do_reset();

        // Boot cycle: still no valid output.
        step(1, 0, 0, 0);
        check("boot_valid", 32'(bus.o_valid), 32'd0);
        // Sequential fetch 0, 4, 8.
        step(1, 0, 0, 0);
        check("seq0_pc", bus.o_instr_pc, 32'h0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("seq8_pc", bus.o_instr_pc, 32'h8);
        // Stall three cycles: output register and PC hold.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            check("stall_ipc", bus.o_instr_pc, 32'h8);
            check("stall_pc", bus.o_pc, 32'hC);
        end
        step(1, 0, 0, 0);
        check("unstall_ipc", bus.o_instr_pc, 32'hC);
        step(1, 0, 0, 0);
        // Redirect while stalled on 0x10.
        step(0, 1, 32'h100, 0);
        check("redir_valid", 32'(bus.o_valid), 32'd0);
        check("redir_pc", bus.o_pc, 32'h100);
        step(1, 0, 0, 0);
        check("redir_ipc", bus.o_instr_pc, 32'h100);
        check("redir_v1", 32'(bus.o_valid), 32'd1);
        // Misaligned redirect faults and halts; later redirects ignored.
        step(1, 1, 32'h102, 0);
        check("mis_fault", 32'(bus.o_fault), 32'd1);
        check("mis_halt", 32'(bus.o_halted), 32'd1);
        check("mis_pc", bus.o_pc, 32'h104);
        step(1, 1, 32'h200, 0);
        check("halt_ignore_pc", bus.o_pc, 32'h104);
        do_reset();
        check("rst_fault", 32'(bus.o_fault), 32'd0);

        // Run up to the IMEM boundary.
        step(1, 0, 0, 0);
        step(1, 1, 32'h7F0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        check("edge_ipc", bus.o_instr_pc, 32'h7FC);
        check("edge_v", 32'(bus.o_valid), 32'd1);
        check("edge_pc", bus.o_pc, 32'h800);
        step(1, 0, 0, 0);
        check("oor_fault", 32'(bus.o_fault), 32'd1);
        check("oor_halt", 32'(bus.o_halted), 32'd1);
        check("oor_valid", 32'(bus.o_valid), 32'd0);
        step(1, 0, 0, 0);

        // Halt request keeps its same-cycle load, then drains.
        do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        check("hreq_halt", 32'(bus.o_halted), 32'd1);
        check("hreq_ipc", bus.o_instr_pc, 32'h4);
        step(0, 1, 32'h40, 0);
        check("hreq_hold_v", 32'(bus.o_valid), 32'd1);
        check("hreq_pc", bus.o_pc, 32'h8);
        step(1, 0, 0, 0);
        check("hreq_drain", 32'(bus.o_valid), 32'd0);

`ifdef FETCH_PERF_CNT_EN
        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(1, 1, 32'h20, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("perf_fetch", o_fetch_cnt, 32'd7);
        check("perf_flush", o_flush_cnt, 32'd1);
`endif

        // Randomized traffic, including a mid-run asynchronous reset.
        for (int ph = 0; ph < 25; ph++) begin
            do_reset();
            post = 0;
            for (int c = 0; c < 80; c++) begin
                rdy = ($urandom_range(0, 3) != 0);
                rd  = ($urandom_range(0, 9) == 0);
                hlt = ($urandom_range(0, 49) == 0);
                r   = int'($urandom_range(0, 15));
                if (r == 0)
                    rpc = ($urandom_range(0, 511) << 2) | $urandom_range(1, 3);
                else if (r < 4)
                    rpc = 32'h7E0 + ($urandom_range(0, 7) << 2);
                else if (r == 4)
                    rpc = 32'h800 + ($urandom_range(0, 15) << 2);
                else
                    rpc = $urandom_range(0, 511) << 2;
                step(rdy, rd, rpc, hlt);
                if (ph == 7 && c == 20) break;
                if (m_halt) begin
                    post++;
                    if (post > 4) break;
                end
            end
        end
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
